// File: rtl/irq_encoder8x3_pkg.sv
// Shared constants and state encoding for the 8-line interrupt request encoder.
package irq_encoder8x3_pkg;
  localparam int IRQ_N = 8;
  localparam int IRQ_W = 3;

  typedef enum logic {
    IRQ_IDLE    = 1'b0,
    IRQ_PRESENT = 1'b1
  } irq_state_e;
endpackage

// File: rtl/irq_encoder8x3_prienc8x3.sv
// Combinational lowest-index priority encoder: bit 0 wins; all-zero input
// yields index 0 with the any flag low.
module prienc8x3
  import irq_encoder8x3_pkg::*;
(
  input  logic [IRQ_N-1:0] vec_i,
  output logic [IRQ_W-1:0] idx_o,
  output logic             any_o
);

  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    // Scan from the top so the lowest set bit is the last to assign.
    for (int i = IRQ_N - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = IRQ_W'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_encoder8x3.sv
// Edge-latched, maskable request encoder presenting one code at a time with a
// valid/ack handshake; the presented code is held until acknowledged.
module irq_encoder8x3
  import irq_encoder8x3_pkg::*;
#(
  parameter logic [IRQ_N-1:0] MASK_RESET = 8'hFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IRQ_N-1:0] req,
  input  logic             mask_we,
  input  logic [IRQ_N-1:0] mask_wdata,
  output logic [IRQ_N-1:0] mask,
  output logic [IRQ_N-1:0] pending,
  output logic             valid,
  output logic [IRQ_W-1:0] code,
  input  logic             ack
);

  irq_state_e       state_q, state_d;
  logic [IRQ_W-1:0] code_q, code_d;
  logic [IRQ_N-1:0] pending_q, pending_d;
  logic [IRQ_N-1:0] mask_q, mask_d;
  logic [IRQ_N-1:0] req_prev_q;

  logic [IRQ_N-1:0] rise;
  logic [IRQ_N-1:0] clr;
  logic [IRQ_N-1:0] enabled;
  logic [IRQ_W-1:0] sel;
  logic             sel_any;

  assign rise    = req & ~req_prev_q;
  assign enabled = pending_q & mask_q;
  assign clr     = (state_q == IRQ_PRESENT && ack) ? (IRQ_N'(1) << code_q) : '0;

  prienc8x3 u_prienc (
    .vec_i (enabled),
    .idx_o (sel),
    .any_o (sel_any)
  );

  // Applying the set after the clear lets a same-cycle new edge win.
  always_comb begin
    pending_d = (pending_q & ~clr) | rise;
    mask_d    = mask_we ? mask_wdata : mask_q;
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    unique case (state_q)
      IRQ_IDLE: begin
        if (sel_any) begin
          state_d = IRQ_PRESENT;
          code_d  = sel;
        end
      end
      IRQ_PRESENT: begin
        if (ack) begin
          state_d = IRQ_IDLE;
          code_d  = '0;
        end
      end
      default: begin
        state_d = IRQ_IDLE;
        code_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IRQ_IDLE;
      code_q     <= '0;
      pending_q  <= '0;
      mask_q     <= MASK_RESET;
      req_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      req_prev_q <= req;
    end
  end

  assign mask    = mask_q;
  assign pending = pending_q;
  assign valid   = (state_q == IRQ_PRESENT);
  assign code    = code_q;

endmodule

// File: tb/tb_irq_encoder8x3.sv
// Directed and randomized checks of irq_encoder8x3 against a behavioural
// model, plus an exhaustive sweep of the standalone priority encoder.
module tb_irq_encoder8x3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = '0;
  logic       mask_we = 1'b0;
  logic [7:0] mask_wdata = '0;
  logic [7:0] mask;
  logic [7:0] pending;
  logic       valid;
  logic [2:0] code;
  logic       ack = 1'b0;

  logic [7:0] pe_vec = '0;
  logic [2:0] pe_idx;
  logic       pe_any;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state
  bit m_pend [8];
  bit m_mask [8];
  bit m_prev [8];
  bit m_presenting;
  int m_code;

  always #5 clk = ~clk;

  irq_encoder8x3 #(.MASK_RESET(8'hFF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .mask       (mask),
    .pending    (pending),
    .valid      (valid),
    .code       (code),
    .ack        (ack)
  );

  prienc8x3 u_pe (
    .vec_i (pe_vec),
    .idx_o (pe_idx),
    .any_o (pe_any)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pack(input bit a [8]);
    logic [7:0] v = '0;
    for (int i = 0; i < 8; i++) v[i] = a[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_pend[i] = 0;
      m_mask[i] = 1;
      m_prev[i] = 0;
    end
    m_presenting = 0;
    m_code = 0;
  endtask

  // One rising edge of the model, using the inputs as sampled at that edge.
  task automatic model_edge(input logic [7:0] r, input logic we, input logic [7:0] wd, input logic a);
    bit old_pend [8];
    bit old_mask [8];
    int first;
    old_pend = m_pend;
    old_mask = m_mask;
    if (m_presenting && a) m_pend[m_code] = 0;
    for (int i = 0; i < 8; i++)
      if (r[i] && !m_prev[i]) m_pend[i] = 1;
    if (!m_presenting) begin
      first = -1;
      for (int i = 0; i < 8; i++)
        if (first < 0 && old_pend[i] && old_mask[i]) first = i;
      if (first >= 0) begin
        m_presenting = 1;
        m_code = first;
      end
    end else if (a) begin
      m_presenting = 0;
      m_code = 0;
    end
    if (we) for (int i = 0; i < 8; i++) m_mask[i] = wd[i];
    for (int i = 0; i < 8; i++) m_prev[i] = r[i];
  endtask

  task automatic check_model(input string tag);
    check({tag, "_valid"}, {7'b0, valid}, {7'b0, m_presenting});
    check({tag, "_code"}, {5'b0, code}, 8'(m_code));
    check({tag, "_pending"}, pending, pack(m_pend));
    check({tag, "_mask"}, mask, pack(m_mask));
  endtask

  task automatic step(input string tag, input logic [7:0] r, input logic we,
                      input logic [7:0] wd, input logic a);
    @(negedge clk);
    req = r;
    mask_we = we;
    mask_wdata = wd;
    ack = a;
    @(posedge clk);
    model_edge(r, we, wd, a);
    #1;
    check_model(tag);
  endtask

  initial begin
    int ref_idx;
    logic [7:0] rnd_req;
    logic [7:0] v;

    // Standalone priority encoder sweep
    for (int n = 0; n < 256; n++) begin
      pe_vec = 8'(n);
      #1;
      ref_idx = 0;
      for (int i = 7; i >= 0; i--) if (pe_vec[i]) ref_idx = i;
      check("pe_idx", {5'b0, pe_idx}, 8'(ref_idx));
      check("pe_any", {7'b0, pe_any}, {7'b0, (n != 0)});
    end

    // Reset state
    model_reset();
    #12;
    check_model("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single pulse on req[5]
    step("p1_set", 8'h20, 0, 8'h00, 0);
    check("p1_pend", pending, 8'h20);
    step("p1_pres", 8'h00, 0, 8'h00, 0);
    check("p1_code", {5'b0, code}, 8'd5);
    step("p1_ack", 8'h00, 0, 8'h00, 1);
    check("p1_done", {valid, pending[6:0]}, 8'h00);

    // Priority order 1 then 3
    step("pr_set", 8'h0A, 0, 8'h00, 0);
    step("pr_p1", 8'h00, 0, 8'h00, 0);
    check("pr_code1", {5'b0, code}, 8'd1);
    step("pr_ack1", 8'h00, 0, 8'h00, 1);
    step("pr_p3", 8'h00, 0, 8'h00, 0);
    check("pr_code3", {5'b0, code}, 8'd3);
    step("pr_ack3", 8'h00, 0, 8'h00, 1);

    // No preemption
    step("np_set", 8'h40, 0, 8'h00, 0);
    step("np_p6", 8'h00, 0, 8'h00, 0);
    step("np_r0", 8'h01, 0, 8'h00, 0);
    step("np_hold", 8'h00, 0, 8'h00, 0);
    check("np_code6", {5'b0, code}, 8'd6);
    step("np_ack6", 8'h00, 0, 8'h00, 1);
    step("np_p0", 8'h00, 0, 8'h00, 0);
    check("np_code0", {valid, 4'b0, code}, 8'h80);
    step("np_ack0", 8'h00, 0, 8'h00, 1);

    // Masked request stays pending until re-enabled
    step("mk_wr", 8'h00, 1, 8'hFE, 0);
    step("mk_r0", 8'h01, 0, 8'h00, 0);
    step("mk_wait", 8'h00, 0, 8'h00, 0);
    check("mk_pend", {valid, pending[6:0]}, 8'h01);
    step("mk_en", 8'h00, 1, 8'hFF, 0);
    step("mk_pres", 8'h00, 0, 8'h00, 0);
    check("mk_code", {valid, 4'b0, code}, 8'h80);
    step("mk_ack", 8'h00, 0, 8'h00, 1);

    // Set/clear collision on bit 2
    step("co_set", 8'h04, 0, 8'h00, 0);
    step("co_p2", 8'h00, 0, 8'h00, 0);
    step("co_hit", 8'h04, 0, 8'h00, 1);
    check("co_pend", pending, 8'h04);
    step("co_again", 8'h00, 0, 8'h00, 0);
    check("co_code", {valid, 4'b0, code}, 8'h82);
    step("co_ack", 8'h00, 0, 8'h00, 1);

    // Asynchronous reset mid-PRESENT
    step("ar_set", 8'hC0, 0, 8'h00, 0);
    step("ar_p6", 8'h00, 0, 8'h00, 0);
    step("ar_mk", 8'h00, 1, 8'h0F, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model("ar_rst");
    req = 8'h10;
    rst_n = 1'b1;
    step("ar_rel1", 8'h10, 0, 8'h00, 0);
    step("ar_rel2", 8'h10, 0, 8'h00, 0);
    check("ar_code4", {valid, 4'b0, code}, 8'h84);
    step("ar_ack", 8'h10, 0, 8'h00, 1);
    step("ar_held", 8'h10, 0, 8'h00, 0);

    // Randomized traffic
    rnd_req = 8'h10;
    for (int n = 0; n < 400; n++) begin
      v = 8'($urandom) & 8'($urandom) & 8'($urandom);
      rnd_req = rnd_req ^ v;
      step("rnd", rnd_req, ($urandom_range(0, 9) == 0), 8'($urandom),
           ($urandom_range(0, 9) < 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
